npu_act_wr_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single activation-memory write port between NUM_NEURONS npu_neuron

---
 rtl/npu_act_wr_arbiter.sv | 141 ++++++++++++++
 tb/tb_npu_act_wr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/npu_act_wr_arbiter.sv
// rtl/npu_act_wr_arbiter.sv - round-robin arbiter sharing the activation-memory write port among neurons,
// with per-layer accepted-write counting, layer-done and excess-write flags.
`timescale 1ns/1ps
module npu_act_wr_arbiter #(
  parameter int NUM_NEURONS = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_NEURONS-1:0]            i_req_wr,
  input  logic [NUM_NEURONS*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_NEURONS-1:0]            o_req_ack_p,
  output logic                              o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0]             o_mem_wr_addr,
  output logic [DATA_WIDTH-1:0]             o_mem_wr_data,
  input  logic                              i_mem_wr_rdy,
  input  logic                              i_layer_start_p,
  input  logic [CNT_WIDTH-1:0]              i_layer_wr_total,
  output logic [CNT_WIDTH-1:0]              o_layer_wr_cnt,
  output logic                              o_layer_done,
  output logic                              o_wr_count_err
);

  localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_ACK} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IW-1:0]           r_ptr;
  logic [IW-1:0]           r_win;
  logic [NUM_NEURONS-1:0]  r_mask;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic                    r_err;

  logic [NUM_NEURONS-1:0]  w_elig;
  logic [NUM_NEURONS-1:0]  w_win_oh;
  logic                    w_found;
  logic [IW-1:0]           w_pick;
  logic [IW:0]             w_sum;
  logic [IW-1:0]           w_idx;
  logic                    w_accept;
  logic [CNT_WIDTH-1:0]    w_cnt_inc;
  logic [ADDR_WIDTH-1:0]   w_addr_arr [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]   w_data_arr [NUM_NEURONS];

  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      w_addr_arr[i] = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_data_arr[i] = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The mask hides the neuron acked last cycle, whose request is still visible for one cycle.
  assign w_elig = i_req_wr & ~r_mask;

  // Scan upward from the pointer with wrap; first eligible neuron wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_NEURONS))
        w_sum = w_sum - (IW+1)'(NUM_NEURONS);
      w_idx = w_sum[IW-1:0];
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_win_oh = {{(NUM_NEURONS-1){1'b0}}, 1'b1} << r_win;
  assign w_accept = (r_state == ST_ISSUE) && i_mem_wr_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_found)  w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (w_accept) w_state_nxt = ST_ACK;
      ST_ACK:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr  <= '0;
      r_win  <= '0;
      r_mask <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_mask <= (r_state == ST_ACK) ? w_win_oh : '0;
      if (r_state == ST_IDLE && w_found) begin
        r_win  <= w_pick;
        r_addr <= w_addr_arr[w_pick];
        r_data <= w_data_arr[w_pick];
      end
      if (r_state == ST_ACK)
        r_ptr <= (r_win == IW'(NUM_NEURONS-1)) ? '0 : r_win + 1'b1;
    end
  end

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  // A write accepted alongside layer_start_p is the first write of the new layer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (i_layer_start_p) begin
      r_cnt <= w_accept ? CNT_WIDTH'(1) : '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= w_cnt_inc;
      if (o_layer_done) r_err <= 1'b1;
    end
  end

  assign o_mem_wr_en    = (r_state == ST_ISSUE);
  assign o_mem_wr_addr  = r_addr;
  assign o_mem_wr_data  = r_data;
  assign o_req_ack_p    = (r_state == ST_ACK) ? w_win_oh : '0;
  assign o_layer_wr_cnt = r_cnt;
  assign o_layer_done   = (i_layer_wr_total != '0) && (r_cnt == i_layer_wr_total);
  assign o_wr_count_err = r_err;

endmodule

// File: tb/tb_npu_act_wr_arbiter.sv
// tb/tb_npu_act_wr_arbiter.sv - directed-vector bench for npu_act_wr_arbiter.
`timescale 1ns/1ps
module tb_npu_act_wr_arbiter;

  localparam int NN = 8;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [NN-1:0]  req_wr;
  logic [NN*AW-1:0] req_addr;
  logic [NN*DW-1:0] req_data;
  logic [NN-1:0]  ack;
  logic           en;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  data;
  logic           rdy;
  logic           start;
  logic [CW-1:0]  total;
  logic [CW-1:0]  cnt;
  logic           done;
  logic           err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  npu_act_wr_arbiter #(
    .NUM_NEURONS(NN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
  ) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_wr(req_wr), .i_req_addr(req_addr), .i_req_data(req_data),
    .o_req_ack_p(ack),
    .o_mem_wr_en(en), .o_mem_wr_addr(addr), .o_mem_wr_data(data),
    .i_mem_wr_rdy(rdy),
    .i_layer_start_p(start), .i_layer_wr_total(total),
    .o_layer_wr_cnt(cnt), .o_layer_done(done), .o_wr_count_err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[idx*AW +: AW] = a;
    req_data[idx*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_wr = '0;
    rdy = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise one request, wait (bounded) for its ack, then drop it.
  task automatic do_write(input int idx, input string tag);
    int t;
    req_wr[idx] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (ack == '0 && t < 20);
    chk(tag, ack, 64'd1 << idx);
    req_wr[idx] = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!en && t < 20);
    chk(tag, en, 1);
  endtask

  initial begin
    int t;
    logic [AW-1:0] cap;
    req_addr = '0;
    req_data = '0;
    total = '0;
    do_reset();

    chk("rst_en", en, 0);
    chk("rst_ack", ack, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // Single requester latency
    set_req(2, 10'h010, 8'h5A);
    req_wr = 8'h04;
    @(negedge clk);
    chk("t1_en", en, 1);
    chk("t1_addr", addr, 10'h010);
    chk("t1_data", data, 8'h5A);
    chk("t1_ack_early", ack, 0);
    @(negedge clk);
    chk("t1_ack", ack, 8'h04);
    chk("t1_en_off", en, 0);
    req_wr = '0;
    @(negedge clk);
    chk("t1_ack_once", ack, 0);
    chk("t1_cnt", cnt, 1);

    // All neurons requesting: round-robin order 0..7
    do_reset();
    for (int i = 0; i < NN; i++) set_req(i, AW'(10'h020 + i), DW'(8'h11 * i));
    req_wr = 8'hFF;
    for (int g = 0; g < NN; g++) begin
      t = 0;
      cap = '0;
      do begin
        @(negedge clk);
        t++;
        if (en) cap = addr;
      end while (ack == '0 && t < 20);
      chk("rr_grant", ack, 64'd1 << g);
      chk("rr_addr", cap, 10'h020 + g);
      req_wr[g] = 1'b0;
    end
    @(negedge clk);
    chk("rr_cnt", cnt, 8);
    chk("rr_done_tot0", done, 0);

    // Memory stall: outputs held while rdy low
    set_req(5, 10'h155, 8'hC3);
    rdy = 1'b0;
    req_wr[5] = 1'b1;
    wait_en("st_en_start");
    for (int i = 0; i < 6; i++) begin
      chk("st_en", en, 1);
      chk("st_addr", addr, 10'h155);
      chk("st_data", data, 8'hC3);
      chk("st_noack", ack, 0);
      if (i == 5) rdy = 1'b1;
      @(negedge clk);
    end
    chk("st_ack", ack, 8'h20);
    chk("st_en_off", en, 0);
    req_wr[5] = 1'b0;

    // Layer accounting with total=3
    total = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ly_cnt_clr", cnt, 0);
    chk("ly_done_clr", done, 0);
    set_req(1, 10'h001, 8'h01);
    do_write(1, "ly_w1");
    do_write(1, "ly_w2");
    chk("ly_done_2", done, 0);
    do_write(1, "ly_w3");
    chk("ly_cnt_3", cnt, 3);
    chk("ly_done_3", done, 1);
    chk("ly_err_3", err, 0);
    do_write(1, "ly_w4");
    chk("ly_cnt_4", cnt, 4);
    chk("ly_err_4", err, 1);
    chk("ly_done_4", done, 0);

    // layer_start_p coincident with an accepted write
    do_write(1, "ls_w5");
    do_write(1, "ls_w6");
    do_write(1, "ls_w7");
    chk("ls_cnt_7", cnt, 7);
    chk("ls_err_7", err, 1);
    set_req(3, 10'h033, 8'h33);
    rdy = 1'b0;
    req_wr[3] = 1'b1;
    wait_en("ls_en");
    rdy = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ls_ack", ack, 8'h08);
    chk("ls_cnt", cnt, 1);
    chk("ls_done", done, 0);
    chk("ls_err", err, 0);
    req_wr[3] = 1'b0;

    // Reset while a write is stalled in ISSUE
    set_req(4, 10'h044, 8'h44);
    rdy = 1'b0;
    req_wr[4] = 1'b1;
    wait_en("rs_en");
    rst = 1'b1;
    #1;
    chk("rs_en_off", en, 0);
    chk("rs_ack", ack, 0);
    chk("rs_addr", addr, 0);
    chk("rs_cnt", cnt, 0);
    chk("rs_err", err, 0);
    @(negedge clk);
    chk("rs_ack_hold", ack, 0);
    set_req(0, 10'h100, 8'hA0);
    set_req(7, 10'h107, 8'hA7);
    req_wr = 8'h81;
    rdy = 1'b1;
    rst = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (ack == '0 && t < 20);
    chk("rs_first", ack, 8'h01);
    req_wr[0] = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (ack == '0 && t < 20);
    chk("rs_second", ack, 8'h80);
    req_wr[7] = 1'b0;
    @(negedge clk);
    chk("rs_cnt_end", cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
